// File: rtl/serial_bus_arbiter_pkg.sv
// Shared types and defaults for the serialized write/read bus arbiter.
package serial_bus_arbiter_pkg;

   localparam int SERBUS_ADDR_W = 8;
   localparam int SERBUS_DATA_W = 16;
   localparam int SERBUS_BUS_W  = 8;

   typedef enum logic [1:0] {
      SERBUS_IDLE   = 2'd0,
      SERBUS_SEND   = 2'd1,
      SERBUS_COMMIT = 2'd2
   } serbus_state_e;

   function automatic int serbus_beats(input int payload_w, input int bus_w);
      return (payload_w + bus_w - 1) / bus_w;
   endfunction

   function automatic int serbus_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_bus_arbiter_rr_arbiter.sv
// Combinational winner select: round-robin from i_rr_ptr, or lowest index
// first when SERBUS_FIXED_PRIO_EN is defined (the pointer input then disappears).
module serial_bus_arbiter_rr_arbiter
   import serial_bus_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = serbus_idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
`ifndef SERBUS_FIXED_PRIO_EN
   input  logic [IDX_W-1:0]   i_rr_ptr,
`endif
   output logic [NUM_REQ-1:0] o_gnt_oh,
   output logic [IDX_W-1:0]   o_gnt_idx,
   output logic               o_any
);

`ifndef SERBUS_FIXED_PRIO_EN
   logic [IDX_W-1:0] w_j;
`endif

   always_comb begin
      o_any     = 1'b0;
      o_gnt_idx = '0;
`ifdef SERBUS_FIXED_PRIO_EN
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (i_req[IDX_W'(k)]) begin
            o_any     = 1'b1;
            o_gnt_idx = IDX_W'(k);
         end
      end
`else
      w_j = '0;
      // Walk upward from the pointer with wrap; the first requester seen wins.
      for (int k = 0; k < NUM_REQ; k++) begin
         w_j = IDX_W'((int'(i_rr_ptr) + k) % NUM_REQ);
         if (!o_any && i_req[w_j]) begin
            o_any     = 1'b1;
            o_gnt_idx = w_j;
         end
      end
`endif
      o_gnt_oh = o_any ? (NUM_REQ'(1) << o_gnt_idx) : '0;
   end

endmodule

// File: rtl/serial_bus_arbiter.sv
// Grants one requester at a time and serializes its {addr, data} payload onto
// a narrow bus, followed by a one-cycle commit. SERBUS_FIXED_PRIO_EN selects fixed priority.
module serial_bus_arbiter
   import serial_bus_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = SERBUS_ADDR_W,
   parameter int DATA_W  = SERBUS_DATA_W,
   parameter int BUS_W   = SERBUS_BUS_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        done,
   output logic                      bus_send,
   output logic                      bus_write,
   output logic [BUS_W-1:0]          bus_data,
   output logic                      busy
);

   localparam int PAYLOAD_W = ADDR_W + DATA_W;
   localparam int BEATS     = serbus_beats(PAYLOAD_W, BUS_W);
   localparam int PAD_W     = BEATS * BUS_W;
   localparam int IDX_W     = serbus_idx_w(NUM_REQ);
   localparam int CNT_W     = serbus_idx_w(BEATS);

   serbus_state_e        r_state, w_state_nxt;
   logic [PAD_W-1:0]     r_payload, w_payload_nxt, w_payload_sel;
   logic [CNT_W-1:0]     r_beat_cnt, w_cnt_nxt, w_cnt_inc;
   logic [IDX_W-1:0]     r_win_idx, w_idx_nxt;
   logic [NUM_REQ-1:0]   r_gnt, w_gnt_nxt, r_done, w_done_nxt;
   logic                 r_bus_send, w_send_nxt, r_bus_write, w_write_nxt;
   logic [BUS_W-1:0]     r_bus_data, w_data_nxt;
   logic                 r_busy, w_busy_nxt;
   logic [NUM_REQ-1:0]   w_arb_gnt;
   logic [IDX_W-1:0]     w_arb_idx;
   logic                 w_arb_any;
   logic [ADDR_W-1:0]    w_addr [NUM_REQ];
   logic [DATA_W-1:0]    w_data [NUM_REQ];
   logic [BUS_W-1:0]     w_beat [BEATS];
`ifndef SERBUS_FIXED_PRIO_EN
   logic [IDX_W-1:0]     r_rr_ptr, w_rr_nxt;
`endif

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign w_addr[i] = req_addr[i*ADDR_W +: ADDR_W];
      assign w_data[i] = req_data[i*DATA_W +: DATA_W];
   end

   // Beat k is payload bits [k*BUS_W +: BUS_W]; bits above PAYLOAD_W are zero.
   for (genvar k = 0; k < BEATS; k++) begin : g_beat
      assign w_beat[k] = r_payload[k*BUS_W +: BUS_W];
   end

   serial_bus_arbiter_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .i_req     (req),
`ifndef SERBUS_FIXED_PRIO_EN
      .i_rr_ptr  (r_rr_ptr),
`endif
      .o_gnt_oh  (w_arb_gnt),
      .o_gnt_idx (w_arb_idx),
      .o_any     (w_arb_any)
   );

   assign w_payload_sel = PAD_W'({w_addr[w_arb_idx], w_data[w_arb_idx]});
   assign w_cnt_inc     = r_beat_cnt + 1'b1;

   always_comb begin
      w_state_nxt   = r_state;
      w_payload_nxt = r_payload;
      w_cnt_nxt     = r_beat_cnt;
      w_idx_nxt     = r_win_idx;
      w_gnt_nxt     = r_gnt;
      w_done_nxt    = '0;
      w_send_nxt    = 1'b0;
      w_write_nxt   = r_bus_write;
      w_data_nxt    = '0;
      w_busy_nxt    = r_busy;
`ifndef SERBUS_FIXED_PRIO_EN
      w_rr_nxt      = r_rr_ptr;
`endif
      case (r_state)
         SERBUS_IDLE: begin
            if (w_arb_any) begin
               w_state_nxt   = SERBUS_SEND;
               w_payload_nxt = w_payload_sel;
               w_cnt_nxt     = '0;
               w_idx_nxt     = w_arb_idx;
               w_gnt_nxt     = w_arb_gnt;
               w_send_nxt    = 1'b1;
               w_write_nxt   = req_write[w_arb_idx];
               w_data_nxt    = w_payload_sel[BUS_W-1:0];
               w_busy_nxt    = 1'b1;
            end else begin
               w_gnt_nxt   = '0;
               w_write_nxt = 1'b0;
               w_busy_nxt  = 1'b0;
            end
         end
         SERBUS_SEND: begin
            if (r_beat_cnt == CNT_W'(BEATS - 1)) begin
               w_state_nxt = SERBUS_COMMIT;
               w_done_nxt  = NUM_REQ'(1) << r_win_idx;
            end else begin
               w_cnt_nxt  = w_cnt_inc;
               w_send_nxt = 1'b1;
               w_data_nxt = w_beat[w_cnt_inc];
            end
         end
         SERBUS_COMMIT: begin
            // bus_write stays up through this cycle so the far end commits now.
            w_state_nxt = SERBUS_IDLE;
            w_gnt_nxt   = '0;
            w_write_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
`ifndef SERBUS_FIXED_PRIO_EN
            w_rr_nxt    = (r_win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_win_idx + 1'b1;
`endif
         end
         default: w_state_nxt = SERBUS_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= SERBUS_IDLE;
         r_beat_cnt  <= '0;
         r_win_idx   <= '0;
         r_gnt       <= '0;
         r_done      <= '0;
         r_bus_send  <= 1'b0;
         r_bus_write <= 1'b0;
         r_bus_data  <= '0;
         r_busy      <= 1'b0;
`ifndef SERBUS_FIXED_PRIO_EN
         r_rr_ptr    <= '0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_beat_cnt  <= w_cnt_nxt;
         r_win_idx   <= w_idx_nxt;
         r_gnt       <= w_gnt_nxt;
         r_done      <= w_done_nxt;
         r_bus_send  <= w_send_nxt;
         r_bus_write <= w_write_nxt;
         r_bus_data  <= w_data_nxt;
         r_busy      <= w_busy_nxt;
`ifndef SERBUS_FIXED_PRIO_EN
         r_rr_ptr    <= w_rr_nxt;
`endif
      end
   end

   always_ff @(posedge clk) begin
      r_payload <= w_payload_nxt;
   end

   assign gnt       = r_gnt;
   assign done      = r_done;
   assign bus_send  = r_bus_send;
   assign bus_write = r_bus_write;
   assign bus_data  = r_bus_data;
   assign busy      = r_busy;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Scoreboard bench for serial_bus_arbiter: expected beats/dones are queued at
// drive time and checked as the bus produces them; a BUS_W=10 instance checks padding.
module tb_serial_bus_arbiter;

   localparam int NR   = 2;
   localparam int AW   = 8;
   localparam int DW   = 16;
   localparam int BW   = 8;
   localparam int BW10 = 10;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [NR-1:0]    req, req_write, gnt, done;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_data;
   logic             bus_send, bus_write, busy;
   logic [BW-1:0]    bus_data;

   logic [NR-1:0]    req_b, req_write_b, gnt_b, done_b;
   logic [NR*AW-1:0] req_addr_b;
   logic [NR*DW-1:0] req_data_b;
   logic             bus_send_b, bus_write_b, busy_b;
   logic [BW10-1:0]  bus_data_b;

   serial_bus_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .BUS_W(BW)) u_dut (
      .clk(clk), .reset(reset), .req(req), .req_write(req_write),
      .req_addr(req_addr), .req_data(req_data), .gnt(gnt), .done(done),
      .bus_send(bus_send), .bus_write(bus_write), .bus_data(bus_data), .busy(busy));

   serial_bus_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .BUS_W(BW10)) u_dut10 (
      .clk(clk), .reset(reset), .req(req_b), .req_write(req_write_b),
      .req_addr(req_addr_b), .req_data(req_data_b), .gnt(gnt_b), .done(done_b),
      .bus_send(bus_send_b), .bus_write(bus_write_b), .bus_data(bus_data_b), .busy(busy_b));

   typedef struct {
      logic [BW-1:0] data;
      logic          wr;
      logic [NR-1:0] oh;
      logic          last;
   } beat_t;

   typedef struct {
      logic [NR-1:0] oh;
      logic          wr;
   } done_t;

   beat_t beat_q[$];
   done_t done_q[$];
   int    total = 0;
   int    bad   = 0;
   logic  last_seen = 1'b0;
   logic  prev_last = 1'b0;
   logic  cur_last  = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic push_xfer(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      logic [AW+DW-1:0] p;
      beat_t            b;
      done_t            de;
      p = {a, d};
      for (int k = 0; k < 3; k++) begin
         b.data = p[k*BW +: BW];
         b.wr   = wr;
         b.oh   = NR'(1) << i;
         b.last = (k == 2);
         beat_q.push_back(b);
      end
      de.oh = NR'(1) << i;
      de.wr = wr;
      done_q.push_back(de);
   endtask

   task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_write[i]        = wr;
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
      req[i]              = 1'b1;
   endtask

   // Requesters hold req until their done pulse, then drop it.
   task automatic wait_idle(input int budget);
      logic ok;
      ok = 1'b0;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk); #1;
         if (done != '0) req = req & ~done;
         if (beat_q.size() == 0 && done_q.size() == 0 && !busy && req == '0) begin
            ok = 1'b1;
            break;
         end
      end
      check_eq("idle_reached", 32'(ok), 32'd1);
      check_eq("gnt_after", 32'(gnt), 32'd0);
      check_eq("write_after", 32'(bus_write), 32'd0);
   endtask

   always @(negedge clk) begin
      cur_last = 1'b0;
      if (reset) begin
         prev_last = 1'b0;
         last_seen = 1'b0;
      end else begin
         if (prev_last) check_eq("done_follows_last", 32'(|done), 32'd1);
         if (bus_send) begin
            if (beat_q.size() == 0) begin
               check_eq("beat_unexpected", 32'(bus_send), 32'd0);
            end else begin
               beat_t e;
               e = beat_q.pop_front();
               check_eq("beat_data", 32'(bus_data), 32'(e.data));
               check_eq("beat_write", 32'(bus_write), 32'(e.wr));
               check_eq("beat_gnt", 32'(gnt), 32'(e.oh));
               cur_last  = e.last;
               last_seen = e.last;
            end
         end
         if (done != '0) begin
            if (done_q.size() == 0) begin
               check_eq("done_unexpected", 32'(done), 32'd0);
            end else begin
               done_t de;
               de = done_q.pop_front();
               check_eq("done", 32'(done), 32'(de.oh));
               check_eq("commit_write", 32'(bus_write), 32'(de.wr));
               check_eq("commit_send", 32'(bus_send), 32'd0);
               check_eq("commit_data", 32'(bus_data), 32'd0);
               check_eq("commit_gnt", 32'(gnt), 32'(de.oh));
               check_eq("done_after_last", 32'(last_seen), 32'd1);
               last_seen = 1'b0;
            end
         end
         prev_last = cur_last;
      end
   end

   initial begin
      logic [BW10-1:0] exp10 [3];
      exp10[0] = 10'h3FF;
      exp10[1] = 10'h3FF;
      exp10[2] = 10'h00F;
      req = '0; req_write = '0; req_addr = '0; req_data = '0;
      req_b = '0; req_write_b = '0; req_addr_b = '0; req_data_b = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_gnt", 32'(gnt), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_send", 32'(bus_send), 32'd0);
      check_eq("rst_write", 32'(bus_write), 32'd0);
      check_eq("rst_data", 32'(bus_data), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      #1 reset = 1'b0;

      // Single write: beats EF, BE, 5A then commit.
      @(negedge clk); #1;
      push_xfer(0, 1'b1, 8'h5A, 16'hBEEF);
      set_req(0, 1'b1, 8'h5A, 16'hBEEF);
      @(negedge clk); #1;
      check_eq("lat_send", 32'(bus_send), 32'd1);
      check_eq("lat_busy", 32'(busy), 32'd1);
      wait_idle(20);

      // Both requesting straight after reset: req0 first, then req1.
      reset = 1'b1;
      @(negedge clk); #1;
      reset = 1'b0;
      push_xfer(0, 1'b1, 8'h11, 16'h2233);
      push_xfer(1, 1'b1, 8'h44, 16'h5566);
      set_req(0, 1'b1, 8'h11, 16'h2233);
      set_req(1, 1'b1, 8'h44, 16'h5566);
      wait_idle(40);

      // Pointer is back at 0 after req1: both again gives req0 first.
      push_xfer(0, 1'b0, 8'h21, 16'h0102);
      push_xfer(1, 1'b1, 8'h31, 16'hA0B0);
      set_req(0, 1'b0, 8'h21, 16'h0102);
      set_req(1, 1'b1, 8'h31, 16'hA0B0);
      wait_idle(40);

      // req0 alone, then both: round-robin favours req1 next.
      push_xfer(0, 1'b1, 8'h42, 16'h4242);
      set_req(0, 1'b1, 8'h42, 16'h4242);
      wait_idle(20);
`ifdef SERBUS_FIXED_PRIO_EN
      push_xfer(0, 1'b1, 8'h5C, 16'h1357);
      push_xfer(1, 1'b0, 8'h6D, 16'h2468);
`else
      push_xfer(1, 1'b0, 8'h6D, 16'h2468);
      push_xfer(0, 1'b1, 8'h5C, 16'h1357);
`endif
      set_req(0, 1'b1, 8'h5C, 16'h1357);
      set_req(1, 1'b0, 8'h6D, 16'h2468);
      wait_idle(40);

      // req1 read: beats 00, 00, 03 with bus_write low.
      push_xfer(1, 1'b0, 8'h03, 16'h0000);
      set_req(1, 1'b0, 8'h03, 16'h0000);
      wait_idle(20);

      // Reset while the second beat is on the bus.
      push_xfer(0, 1'b1, 8'hC3, 16'h9A5C);
      set_req(0, 1'b1, 8'hC3, 16'h9A5C);
      @(negedge clk); #1;
      @(negedge clk); #1;
      check_eq("mid_beat1", 32'(bus_data), 32'h9A);
      reset = 1'b1;
      req = '0;
      beat_q.delete();
      done_q.delete();
      @(negedge clk); #1;
      check_eq("mid_rst_gnt", 32'(gnt), 32'd0);
      check_eq("mid_rst_done", 32'(done), 32'd0);
      check_eq("mid_rst_send", 32'(bus_send), 32'd0);
      check_eq("mid_rst_write", 32'(bus_write), 32'd0);
      check_eq("mid_rst_data", 32'(bus_data), 32'd0);
      check_eq("mid_rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      @(negedge clk); #1;
      check_eq("mid_no_done", 32'(done), 32'd0);
      check_eq("mid_idle", 32'(busy), 32'd0);
      push_xfer(0, 1'b0, 8'h0F, 16'h00F0);
      set_req(0, 1'b0, 8'h0F, 16'h00F0);
      wait_idle(20);

      // Inputs change after grant; the latched payload must still go out.
      push_xfer(0, 1'b1, 8'h77, 16'h1234);
      set_req(0, 1'b1, 8'h77, 16'h1234);
      @(negedge clk); #1;
      req[0]         = 1'b0;
      req_write[0]   = 1'b0;
      req_addr[7:0]  = 8'h00;
      req_data[15:0] = 16'hFFFF;
      wait_idle(20);

      // 10-bit bus: 24-bit payload in 3 beats, top beat zero-padded.
      req_write_b[0]    = 1'b1;
      req_addr_b[7:0]   = 8'hFF;
      req_data_b[15:0]  = 16'hFFFF;
      req_b[0]          = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         check_eq("b10_send", 32'(bus_send_b), 32'd1);
         check_eq("b10_beat", 32'(bus_data_b), 32'(exp10[k]));
      end
      @(negedge clk); #1;
      check_eq("b10_done", 32'(done_b), 32'd1);
      check_eq("b10_commit_send", 32'(bus_send_b), 32'd0);
      check_eq("b10_commit_write", 32'(bus_write_b), 32'd1);
      req_b = '0;
      @(negedge clk); #1;
      check_eq("b10_gnt_after", 32'(gnt_b), 32'd0);
      check_eq("b10_done_after", 32'(done_b), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
